// File: rtl/fetch_stage_pkg.sv
// Shared types for the fetch stage: word type, PC-select encoding, fetch FSM states.
// Optional FETCH_STATS_EN build adds an accepted-fetch counter port.
package fetch_stage_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_JUMP   = 2'b01,
    PC_BRANCH = 2'b10,
    PC_JR     = 2'b11
  } pcsrc_t;

  typedef logic [0:0] fetch_state_t;
  localparam fetch_state_t FETCH  = 1'b0;
  localparam fetch_state_t HALTED = 1'b1;

  localparam word_t PC_INIT_DEFAULT = 32'h0000_0000;

  // Branch displacement is a signed word count relative to pc+4.
  function automatic word_t branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: imem handshake, control-unit decode inputs and IF/ID outputs.
// With FETCH_STATS_EN defined the bus also carries fetch_count.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic        ihit;
  word_t       imemload;
  pcsrc_t      pcsrc;
  logic [15:0] imm;
  logic [25:0] addr;
  word_t       jr_target;
  logic        halt;
  logic        stall;
  logic        flush;

  logic        imemREN;
  word_t       imemaddr;
  word_t       instr;
  word_t       npc;
  logic        valid;
  logic        halted;

`ifdef FETCH_STATS_EN
  word_t       fetch_count;

  modport master (
    input  ihit, imemload, pcsrc, imm, addr, jr_target, halt, stall, flush,
    output imemREN, imemaddr, instr, npc, valid, halted, fetch_count
  );

  modport slave (
    output ihit, imemload, pcsrc, imm, addr, jr_target, halt, stall, flush,
    input  imemREN, imemaddr, instr, npc, valid, halted, fetch_count
  );
`else
  modport master (
    input  ihit, imemload, pcsrc, imm, addr, jr_target, halt, stall, flush,
    output imemREN, imemaddr, instr, npc, valid, halted
  );

  modport slave (
    output ihit, imemload, pcsrc, imm, addr, jr_target, halt, stall, flush,
    input  imemREN, imemaddr, instr, npc, valid, halted
  );
`endif

endinterface

// File: rtl/fetch_stage_pc_next.sv
// Combinational next-PC target select from the IF/ID pc+4 and decoded fields.
// Shared with the single-cycle datapath.
module fetch_stage_pc_next
  import fetch_stage_pkg::*;
(
  input  pcsrc_t      pcsrc,
  input  word_t       npc,
  input  logic [15:0] imm,
  input  logic [25:0] addr,
  input  word_t       jr_target,
  output word_t       target
);

  always_comb begin
    target = npc;
    case (pcsrc)
      PC_SEQ:    target = npc;
      PC_JUMP:   target = {npc[31:28], addr, 2'b00};
      PC_BRANCH: target = npc + branch_offset(imm);
      PC_JR:     target = jr_target;
      default:   target = npc;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem read handshake, IF/ID register and halt FSM.
// Define FETCH_STATS_EN to add a saturating accepted-fetch counter (fetch_count).
//
// state  | meaning
// FETCH  | reading imem at pc, filling IF/ID
// HALTED | fetch stopped for good; only nRST leaves
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter word_t PC_INIT = PC_INIT_DEFAULT
) (
  input logic           CLK,
  input logic           nRST,
  fetch_stage_if.master bus
);

  fetch_state_t state;
  word_t        pc;
  word_t        instr_q;
  word_t        npc_q;
  logic         valid_q;
  word_t        target;
  word_t        pc_plus4;
  logic         redirect;

  fetch_stage_pc_next u_pc_next (
    .pcsrc     (bus.pcsrc),
    .npc       (npc_q),
    .imm       (bus.imm),
    .addr      (bus.addr),
    .jr_target (bus.jr_target),
    .target    (target)
  );

  assign pc_plus4 = pc + 32'd4;
  // Decode belongs to the IF/ID entry, so it only counts while that entry is live.
  assign redirect = valid_q && (bus.pcsrc != PC_SEQ) && !bus.stall;

`ifdef FETCH_STATS_EN
  word_t fetch_count_q;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= FETCH;
      pc      <= PC_INIT;
      instr_q <= '0;
      npc_q   <= '0;
      valid_q <= 1'b0;
`ifdef FETCH_STATS_EN
      fetch_count_q <= '0;
`endif
    end else if (state == FETCH) begin
      if (bus.halt && valid_q && !bus.stall) begin
        state   <= HALTED;
        valid_q <= 1'b0;
      end else if (bus.stall) begin
        // hold everything; a word returned now is refetched after the stall
      end else if (bus.flush) begin
        valid_q <= 1'b0;
        if (bus.ihit) pc <= pc_plus4;
      end else if (redirect) begin
        pc      <= target;
        valid_q <= 1'b0;
      end else if (bus.ihit) begin
        instr_q <= bus.imemload;
        npc_q   <= pc_plus4;
        valid_q <= 1'b1;
        pc      <= pc_plus4;
`ifdef FETCH_STATS_EN
        if (fetch_count_q != 32'hFFFF_FFFF) fetch_count_q <= fetch_count_q + 32'd1;
`endif
      end else begin
        valid_q <= 1'b0;
      end
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign bus.imemREN  = (state == FETCH);
  assign bus.imemaddr = pc;
  assign bus.instr    = instr_q;
  assign bus.npc      = npc_q;
  assign bus.valid    = valid_q;
  assign bus.halted   = (state == HALTED);
`ifdef FETCH_STATS_EN
  assign bus.fetch_count = fetch_count_q;
`endif

endmodule
